// File: rtl/exp3_unidade_controle.sv
// exp3_unidade_controle: Moore control FSM that sequences the exp3 switch-vs-memory datapath.
// Optional macro TIMEOUT_EN adds an ESPERA timer that ends the pass in FIM_TEMPO.
module exp3_unidade_controle #(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'b0000,
    PREPARA    = 4'b0001,
    ESPERA     = 4'b0010,
    REGISTRA   = 4'b0100,
    COMPARA    = 4'b0101,
    PROXIMO    = 4'b0110,
    FIM_ACERTO = 4'b1010,
    FIM_ERRO   = 4'b1110,
    FIM_TEMPO  = 4'b1101
  } estado_t;

  estado_t    state_r;
  estado_t    next_state_s;
  logic       jogada_d_r;
  logic       jogada_pulso_s;
  logic [7:0] saidas_s;

  assign jogada_pulso_s = jogada & ~jogada_d_r;

  // Output word {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} per state
  function automatic logic [7:0] saidas(input estado_t e);
    case (e)
      PREPARA:    saidas = 8'b1010_0000;
      REGISTRA:   saidas = 8'b0001_0000;
      PROXIMO:    saidas = 8'b0100_0000;
      FIM_ACERTO: saidas = 8'b0000_1100;
      FIM_ERRO:   saidas = 8'b0000_1010;
`ifdef TIMEOUT_EN
      FIM_TEMPO:  saidas = 8'b0000_1011;
`endif
      default:    saidas = 8'b0000_0000;
    endcase
  endfunction

`ifdef TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CICLOS);
  logic [TIMER_W-1:0] timer_r;
  logic               expirou_s;

  assign expirou_s = (timer_r == TIMER_W'(TIMEOUT_CICLOS - 1));

  // ESPERA cycle counter; any cycle spent outside ESPERA leaves it cleared for the next entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= {TIMER_W{1'b0}};
    end else if (state_r == ESPERA && next_state_s == ESPERA) begin
      timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      timer_r <= {TIMER_W{1'b0}};
    end
  end
`endif

  // Next-state logic; unknown codes fall back to INICIAL
  always_comb begin
    next_state_s = INICIAL;
    case (state_r)
      INICIAL: begin
        if (iniciar) next_state_s = PREPARA;
        else         next_state_s = INICIAL;
      end
      PREPARA: next_state_s = ESPERA;
      ESPERA: begin
        if (jogada_pulso_s) next_state_s = REGISTRA;
`ifdef TIMEOUT_EN
        else if (expirou_s) next_state_s = FIM_TEMPO;
`endif
        else                next_state_s = ESPERA;
      end
      REGISTRA: next_state_s = COMPARA;
      // a mismatch outranks the terminal count, so a wrong last play is still an error
      COMPARA: begin
        if (!chavesIgualMemoria) next_state_s = FIM_ERRO;
        else if (fimC)           next_state_s = FIM_ACERTO;
        else                     next_state_s = PROXIMO;
      end
      PROXIMO: next_state_s = ESPERA;
      FIM_ACERTO: begin
        if (iniciar) next_state_s = PREPARA;
        else         next_state_s = FIM_ACERTO;
      end
      FIM_ERRO: begin
        if (iniciar) next_state_s = PREPARA;
        else         next_state_s = FIM_ERRO;
      end
`ifdef TIMEOUT_EN
      FIM_TEMPO: begin
        if (iniciar) next_state_s = PREPARA;
        else         next_state_s = FIM_TEMPO;
      end
`endif
      default: next_state_s = INICIAL;
    endcase
  end

  assign saidas_s = saidas(next_state_s);

  // State, edge-detector history and outputs; outputs are loaded with the decode of the
  // state being entered so they always equal the decode of the current state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= INICIAL;
      jogada_d_r <= 1'b0;
      zeraC      <= 1'b0;
      contaC     <= 1'b0;
      zeraR      <= 1'b0;
      registraR  <= 1'b0;
      pronto     <= 1'b0;
      acertou    <= 1'b0;
      errou      <= 1'b0;
      db_estado  <= 4'b0000;
    end else begin
      state_r    <= next_state_s;
      jogada_d_r <= jogada;
      zeraC      <= saidas_s[7];
      contaC     <= saidas_s[6];
      zeraR      <= saidas_s[5];
      registraR  <= saidas_s[4];
      pronto     <= saidas_s[3];
      acertou    <= saidas_s[2];
      errou      <= saidas_s[1];
      db_estado  <= next_state_s;
    end
  end

`ifdef TIMEOUT_EN
  // Timeout flag follows the same registered decode as the other outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= saidas_s[0];
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Self-checking bench for exp3_unidade_controle: behavioural pass model plus a datapath model
// (address counter, switch register, memory 0001,0010,0100,1000,...) that feeds fimC/compare.
module tb_exp3_unidade_controle;

  localparam int TO = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic [3:0] chaves = 4'b0000;
  logic       chavesIgualMemoria, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cnt_reg = 0;
  int cnt_cnt = 0;
  logic chk_on = 1'b0;

  exp3_unidade_controle #(.TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .jogada(jogada),
    .chavesIgualMemoria(chavesIgualMemoria), .fimC(fimC),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef enum int {M_INI, M_PRE, M_ESP, M_REG, M_CMP, M_PRX, M_ACE, M_ERR, M_TMP} m_state_t;

  m_state_t   m_st;
  logic       m_jd;
  int         m_wait;
  logic [3:0] dp_addr, dp_reg;

  function automatic logic [3:0] mem_word(input logic [3:0] a);
    logic [3:0] one;
    one = 4'b0001;
    return one << a[1:0];
  endfunction

  assign fimC = (dp_addr == 4'd15);
  assign chavesIgualMemoria = (dp_reg == mem_word(dp_addr));

  // Expected {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [11:0] exp_vec(input m_state_t s);
    case (s)
      M_PRE:   return {4'b0001, 8'b1010_0000};
      M_ESP:   return {4'b0010, 8'b0000_0000};
      M_REG:   return {4'b0100, 8'b0001_0000};
      M_CMP:   return {4'b0101, 8'b0000_0000};
      M_PRX:   return {4'b0110, 8'b0100_0000};
      M_ACE:   return {4'b1010, 8'b0000_1100};
      M_ERR:   return {4'b1110, 8'b0000_1010};
      M_TMP:   return {4'b1101, 8'b0000_1011};
      default: return 12'h000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  // Reference: pass progress plus datapath reacting to the model's own strobes
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= M_INI; m_jd <= 1'b0; m_wait <= 0; dp_addr <= 4'd0; dp_reg <= 4'd0;
    end else begin
      m_jd   <= jogada;
      m_wait <= 0;
      if (m_st == M_PRE) begin dp_addr <= 4'd0; dp_reg <= 4'd0; end
      if (m_st == M_REG) dp_reg <= chaves;
      if (m_st == M_PRX) dp_addr <= dp_addr + 4'd1;
      case (m_st)
        M_INI, M_ACE, M_ERR, M_TMP: if (iniciar) m_st <= M_PRE;
        M_PRE: m_st <= M_ESP;
        M_ESP: begin
          if (jogada && !m_jd) m_st <= M_REG;
`ifdef TIMEOUT_EN
          else if (m_wait == TO - 1) m_st <= M_TMP;
          else m_wait <= m_wait + 1;
`endif
        end
        M_REG: m_st <= M_CMP;
        M_CMP: begin
          if (dp_reg != mem_word(dp_addr)) m_st <= M_ERR;
          else if (dp_addr == 4'd15)       m_st <= M_ACE;
          else                             m_st <= M_PRX;
        end
        M_PRX: m_st <= M_ESP;
        default: m_st <= M_INI;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model, plus strobe counting
  always @(negedge clock) begin
    if (chk_on)
      chk("outputs", 32'({db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}),
          32'(exp_vec(m_st)));
    if (registraR) cnt_reg++;
    if (contaC) cnt_cnt++;
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_state(input m_state_t target, input string name);
    int n = 0;
    while (m_st != target && n < 100) begin cyc(); n++; end
    if (m_st != target) begin
      checks++; errors++;
      $display("FAIL %s: state not reached after %0d cycles, at %0d expected %0d", name, n, m_st, target);
    end
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1; cyc(); iniciar = 1'b0;
  endtask

  task automatic play(input logic [3:0] sw, input int hold);
    wait_state(M_ESP, "wait_espera");
    chaves = sw; jogada = 1'b1;
    repeat (hold) cyc();
    jogada = 1'b0; cyc();
  endtask

  int b_reg, b_cnt;

  initial begin
    repeat (3) cyc();
    chk_on = 1'b1;
    chk("reset_outputs", 32'({db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}), 32'd0);
    reset_n = 1'b1;
    cyc();
    chk("idle_db", 32'(db_estado), 32'h0);
    pulse_iniciar();
    chk("prepara_db", 32'(db_estado), 32'h1);
    chk("prepara_zera", 32'({zeraC, zeraR}), 32'h3);
    cyc();
    chk("espera_db", 32'(db_estado), 32'h2);
    chk("espera_zera", 32'({zeraC, zeraR}), 32'h0);

    // full correct pass
    b_reg = cnt_reg; b_cnt = cnt_cnt;
    for (int i = 0; i < 16; i++) play(mem_word(4'(i)), 1 + int'($urandom_range(2, 0)));
    wait_state(M_ACE, "wait_acerto");
    chk("acerto_db", 32'(db_estado), 32'hA);
    chk("acerto_flags", 32'({pronto, acertou, errou}), 32'h6);
    chk("acerto_registraR_count", 32'(cnt_reg - b_reg), 32'd16);
    chk("acerto_contaC_count", 32'(cnt_cnt - b_cnt), 32'd15);
    chk("model_pin_acerto", 32'(exp_vec(m_st)), 32'hA0C);

    // third play wrong
    b_reg = cnt_reg; b_cnt = cnt_cnt;
    pulse_iniciar();
    play(4'b0001, 1);
    play(4'b0010, 2);
    play(4'b1000, 1);
    wait_state(M_ERR, "wait_erro");
    chk("erro_db", 32'(db_estado), 32'hE);
    chk("erro_flags", 32'({pronto, acertou, errou}), 32'h5);
    chk("erro_contaC_count", 32'(cnt_cnt - b_cnt), 32'd2);
    chk("erro_registraR_count", 32'(cnt_reg - b_reg), 32'd3);

    // jogada held for 10 cycles gives one registration
    pulse_iniciar();
    wait_state(M_ESP, "wait_espera_hold");
    b_reg = cnt_reg;
    chaves = mem_word(dp_addr); jogada = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 7) chk("held_in_espera", 32'(db_estado), 32'h2);
    end
    jogada = 1'b0; cyc();
    chk("held_one_registraR", 32'(cnt_reg - b_reg), 32'd1);

    // idle in ESPERA
    repeat (12) cyc();
`ifdef TIMEOUT_EN
    chk("timeout_db", 32'(db_estado), 32'hD);
    chk("timeout_flags", 32'({pronto, errou, timeout}), 32'h7);
    pulse_iniciar();
`else
    chk("no_timeout", 32'({db_estado, timeout}), 32'h4);
`endif

    // async reset while in PROXIMO
    play(mem_word(dp_addr), 1);
    wait_state(M_PRX, "wait_proximo");
    chk("proximo_contaC", 32'(contaC), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 32'({db_estado, contaC}), 32'd0);
    cyc(); cyc();
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      iniciar = ($urandom_range(9, 0) == 0);
      jogada  = $urandom_range(1, 0) == 1;
      chaves  = ($urandom_range(7, 0) != 0) ? mem_word(dp_addr) : 4'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
